// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: PC-select codes, branch
// condition codes and the sequencer state enum.
package branch_pkg;

  localparam logic [1:0] PCSEL_NPC  = 2'b00;
  localparam logic [1:0] PCSEL_IDTA = 2'b01;
  localparam logic [1:0] PCSEL_EXTA = 2'b10;
  localparam logic [1:0] PCSEL_RS   = 2'b11;

  localparam logic [2:0] COND_BEQ  = 3'd0;
  localparam logic [2:0] COND_BNE  = 3'd1;
  localparam logic [2:0] COND_BLEZ = 3'd2;
  localparam logic [2:0] COND_BGTZ = 3'd3;
  localparam logic [2:0] COND_BLTZ = 3'd4;
  localparam logic [2:0] COND_BGEZ = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COND_WAIT = 2'd1,
    ST_JR_WAIT   = 2'd2
  } state_e;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// Pure combinational branch resolution: maps a condition code and the EX
// compare flags to a taken decision. Codes 6-7 are never taken.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       z_i,
  input  logic       n_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_BEQ:  taken_o = z_i;
      COND_BNE:  taken_o = ~z_i;
      COND_BLEZ: taken_o = z_i | n_i;
      COND_BGTZ: taken_o = ~z_i & ~n_i;
      COND_BLTZ: taken_o = n_i;
      COND_BGEZ: taken_o = ~n_i;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// IF-stage PC-select sequencer for jumps, register jumps and conditional
// branches. Optional macro BRANCH_LIKELY_EN enables delay-slot annulment.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         id_valid,
  input  logic         id_is_branch,
  input  logic         id_is_jump,
  input  logic         id_is_jr,
  input  logic [2:0]   id_cond,
  input  logic         id_likely,
  input  logic         ex_hold,
  input  logic         ex_z,
  input  logic         ex_n,
  input  logic         rs_ready,
  input  logic [W-1:0] id_ta,
  input  logic [W-1:0] ex_ta,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] npc,
  output logic [1:0]   pc_sel,
  output logic [W-1:0] pc_next,
  output logic         take,
  output logic         stall_if_id,
  output logic         flush_if,
  output logic         annul_id,
  output logic         err_sticky,
  output logic [1:0]   dbg_state
);

  state_e     state_q, state_d;
  logic [2:0] cond_q, cond_d;
  logic       err_q, err_d;
  logic       taken;
  logic       id_ctrl;
  logic [1:0] sel_c;
  logic       take_c, stall_c, flush_c, annul_c;

`ifdef BRANCH_LIKELY_EN
  logic       likely_q, likely_d;
`else
  logic       unused_likely;
  assign unused_likely = id_likely;
`endif

  branch_cond_eval u_cond_eval (
    .cond_i  (cond_q),
    .z_i     (ex_z),
    .n_i     (ex_n),
    .taken_o (taken)
  );

  assign id_ctrl = id_is_jump | id_is_jr | id_is_branch;

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    err_d   = err_q;
`ifdef BRANCH_LIKELY_EN
    likely_d = likely_q;
`endif
    sel_c   = PCSEL_NPC;
    take_c  = 1'b0;
    stall_c = 1'b0;
    flush_c = 1'b0;
    annul_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_valid) begin
          if (id_is_jump) begin
            take_c = 1'b1;
            sel_c  = PCSEL_IDTA;
          end else if (id_is_jr) begin
            if (rs_ready) begin
              take_c = 1'b1;
              sel_c  = PCSEL_RS;
            end else begin
              stall_c = 1'b1;
              state_d = ST_JR_WAIT;
            end
          end else if (id_is_branch) begin
            cond_d  = id_cond;
`ifdef BRANCH_LIKELY_EN
            likely_d = id_likely;
`endif
            state_d = ST_COND_WAIT;
          end
        end
      end
      ST_COND_WAIT: begin
        // ID now holds the delay slot: a control op there is illegal, not followed.
        if (id_valid && id_ctrl) err_d = 1'b1;
        if (!ex_hold) begin
          state_d = ST_IDLE;
          if (taken) begin
            take_c  = 1'b1;
            sel_c   = PCSEL_EXTA;
            flush_c = 1'b1;
          end else begin
`ifdef BRANCH_LIKELY_EN
            annul_c = likely_q;
`endif
          end
        end
      end
      ST_JR_WAIT: begin
        if (rs_ready) begin
          take_c  = 1'b1;
          sel_c   = PCSEL_RS;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cond_q  <= 3'd0;
      err_q   <= 1'b0;
`ifdef BRANCH_LIKELY_EN
      likely_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      err_q   <= err_d;
`ifdef BRANCH_LIKELY_EN
      likely_q <= likely_d;
`endif
    end
  end

  // Reset masks every output, so a wait state cannot redirect in its reset cycle.
  assign pc_sel      = reset ? PCSEL_NPC : sel_c;
  assign take        = take_c & ~reset;
  assign stall_if_id = stall_c & ~reset;
  assign flush_if    = flush_c & ~reset;
  assign annul_id    = annul_c & ~reset;
  assign err_sticky  = err_q & ~reset;
  assign dbg_state   = reset ? 2'b00 : state_q;

  always_comb begin
    pc_next = '0;
    if (!reset) begin
      case (sel_c)
        PCSEL_NPC:  pc_next = npc;
        PCSEL_IDTA: pc_next = id_ta;
        PCSEL_EXTA: pc_next = ex_ta;
        default:    pc_next = rs_val;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios with literal
// expectations, then randomized traffic against an in-bench reference model.
module tb_branch_sequencer;
  import branch_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 9;
`ifdef BRANCH_LIKELY_EN
  localparam bit LIKELY_EN = 1'b1;
`else
  localparam bit LIKELY_EN = 1'b0;
`endif

  logic         clk, reset;
  logic         id_valid, id_is_branch, id_is_jump, id_is_jr, id_likely;
  logic [2:0]   id_cond;
  logic         ex_hold, ex_z, ex_n, rs_ready;
  logic [W-1:0] id_ta, ex_ta, rs_val, npc;
  logic [1:0]   pc_sel, dbg_state;
  logic [W-1:0] pc_next;
  logic         take, stall_if_id, flush_if, annul_id, err_sticky;

  branch_sequencer #(.W(W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_is_jump(id_is_jump), .id_is_jr(id_is_jr), .id_cond(id_cond),
    .id_likely(id_likely), .ex_hold(ex_hold), .ex_z(ex_z), .ex_n(ex_n),
    .rs_ready(rs_ready), .id_ta(id_ta), .ex_ta(ex_ta), .rs_val(rs_val), .npc(npc),
    .pc_sel(pc_sel), .pc_next(pc_next), .take(take), .stall_if_id(stall_if_id),
    .flush_if(flush_if), .annul_id(annul_id), .err_sticky(err_sticky),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [EW-1:0] exp_q[$];

  // model: what the sequencer is waiting on, in spec terms
  bit m_br_pending, m_jr_pending, m_likely, m_err;
  int m_cond;
  bit n_br_pending, n_jr_pending, n_likely, n_err_m;
  int n_cond;

  function automatic bit br_taken(int c, bit z, bit n);
    bit t[8];
    t = '{z, !z, z || n, !z && !n, n, !n, 1'b0, 1'b0};
    return t[c];
  endfunction

  task automatic idle_in();
    reset = 1'b0; id_valid = 1'b0; id_is_branch = 1'b0; id_is_jump = 1'b0;
    id_is_jr = 1'b0; id_cond = 3'd0; id_likely = 1'b0; ex_hold = 1'b0;
    ex_z = 1'b0; ex_n = 1'b0; rs_ready = 1'b0;
    id_ta = $urandom; ex_ta = $urandom; rs_val = $urandom; npc = $urandom;
  endtask

  task automatic branch_in(logic [2:0] c, logic lk);
    idle_in();
    id_valid = 1'b1; id_is_branch = 1'b1; id_cond = c; id_likely = lk;
  endtask

  // Compute expected outputs for the current inputs, queue them, advance
  // the model's next state, and wait until the compare edge.
  task automatic step();
    logic [1:0]   sel, ms;
    logic [W-1:0] pcn;
    bit tk, st, fl, an;
    sel = PCSEL_NPC; tk = 0; st = 0; fl = 0; an = 0; ms = ST_IDLE;
    n_br_pending = m_br_pending; n_jr_pending = m_jr_pending;
    n_likely = m_likely; n_cond = m_cond; n_err_m = m_err;
    if (reset) begin
      n_br_pending = 0; n_jr_pending = 0; n_likely = 0; n_cond = 0; n_err_m = 0;
      pcn = '0;
    end else begin
      ms = m_br_pending ? ST_COND_WAIT : (m_jr_pending ? ST_JR_WAIT : ST_IDLE);
      if (m_br_pending) begin
        if (id_valid && (id_is_jump || id_is_jr || id_is_branch)) n_err_m = 1;
        if (!ex_hold) begin
          n_br_pending = 0;
          if (br_taken(m_cond, ex_z, ex_n)) begin tk = 1; sel = PCSEL_EXTA; fl = 1; end
          else an = LIKELY_EN && m_likely;
        end
      end else if (m_jr_pending) begin
        if (rs_ready) begin tk = 1; sel = PCSEL_RS; n_jr_pending = 0; end
        else st = 1;
      end else if (id_valid) begin
        if (id_is_jump) begin tk = 1; sel = PCSEL_IDTA; end
        else if (id_is_jr) begin
          if (rs_ready) begin tk = 1; sel = PCSEL_RS; end
          else begin st = 1; n_jr_pending = 1; end
        end else if (id_is_branch) begin
          n_br_pending = 1; n_cond = int'(id_cond); n_likely = id_likely;
        end
      end
      pcn = (sel == PCSEL_NPC) ? npc : (sel == PCSEL_IDTA) ? id_ta :
            (sel == PCSEL_EXTA) ? ex_ta : rs_val;
    end
    exp_q.push_back({sel, pcn, tk, st, fl, an, (reset ? 1'b0 : m_err), ms});
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_br_pending = n_br_pending; m_jr_pending = n_jr_pending;
    m_likely = n_likely; m_cond = n_cond; m_err = n_err_m;
    cyc++;
  endtask

  task automatic lit(string nm, logic [W-1:0] act, logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
    end
  endtask

  // scoreboard: every cycle's outputs against the model
  always @(negedge clk) begin
    logic [EW-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pc_sel, pc_next, take, stall_if_id, flush_if, annul_id, err_sticky, dbg_state};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL model cycle %0d: got sel=%0d pc=%h tk=%b st=%b fl=%b an=%b er=%b s=%0d expected sel=%0d pc=%h tk=%b st=%b fl=%b an=%b er=%b s=%0d",
                 cyc, a[EW-1:EW-2], a[EW-3:9], a[8], a[7], a[6], a[5], a[4], a[1:0],
                 e[EW-1:EW-2], e[EW-3:9], e[8], e[7], e[6], e[5], e[4], e[1:0]);
      end
    end
  end

  initial begin
    m_br_pending = 0; m_jr_pending = 0; m_likely = 0; m_err = 0; m_cond = 0;
    idle_in(); reset = 1'b1;
    step();
    lit("rst_take", {31'b0, take}, 0);
    lit("rst_sel", {30'b0, pc_sel}, 0);
    lit("rst_pc", pc_next, 0);
    advance(); idle_in(); reset = 1'b1; step();

    // jump in IDLE
    advance(); idle_in(); id_valid = 1; id_is_jump = 1; id_ta = 32'h0040_0100; step();
    lit("jmp_take", {31'b0, take}, 1);
    lit("jmp_sel", {30'b0, pc_sel}, 1);
    lit("jmp_pc", pc_next, 32'h0040_0100);
    advance(); idle_in(); step();
    lit("jmp_state", {30'b0, dbg_state}, ST_IDLE);

    // BEQ taken
    advance(); branch_in(COND_BEQ, 0); step();
    lit("beq_issue_take", {31'b0, take}, 0);
    advance(); idle_in(); ex_z = 1; ex_ta = 32'h0040_0020; step();
    lit("beq_take", {31'b0, take}, 1);
    lit("beq_sel", {30'b0, pc_sel}, 2);
    lit("beq_flush", {31'b0, flush_if}, 1);
    lit("beq_pc", pc_next, 32'h0040_0020);

    // BEQ not taken
    advance(); branch_in(COND_BEQ, 0); step();
    advance(); idle_in(); ex_z = 0; npc = 32'h0040_0008; step();
    lit("beqnt_sel", {30'b0, pc_sel}, 0);
    lit("beqnt_pc", pc_next, 32'h0040_0008);
    lit("beqnt_take", {31'b0, take}, 0);

    // BGTZ held two cycles
    advance(); branch_in(COND_BGTZ, 0); step();
    for (int i = 0; i < 2; i++) begin
      advance(); idle_in(); ex_hold = 1; step();
      lit("bgtz_hold_take", {31'b0, take}, 0);
    end
    advance(); idle_in(); ex_z = 0; ex_n = 0; step();
    lit("bgtz_take", {31'b0, take}, 1);

    // jr stalled three cycles
    for (int i = 0; i < 3; i++) begin
      advance(); idle_in(); id_valid = 1; id_is_jr = 1; rs_val = 32'h0040_0300; step();
      lit("jr_stall", {31'b0, stall_if_id}, 1);
    end
    advance(); idle_in(); id_valid = 1; id_is_jr = 1; rs_ready = 1; rs_val = 32'h0040_0300; step();
    lit("jr_take", {31'b0, take}, 1);
    lit("jr_sel", {30'b0, pc_sel}, 3);
    lit("jr_pc", pc_next, 32'h0040_0300);
    lit("jr_stall_rel", {31'b0, stall_if_id}, 0);

    // jump in delay slot
    advance(); branch_in(COND_BEQ, 0); step();
    advance(); idle_in(); id_valid = 1; id_is_jump = 1; id_ta = 32'h0040_0500; step();
    lit("ds_take", {31'b0, take}, 0);
    lit("ds_sel", {30'b0, pc_sel}, 0);
    advance(); idle_in(); step();
    lit("ds_err", {31'b0, err_sticky}, 1);

    // reset while in JR_WAIT
    advance(); idle_in(); id_valid = 1; id_is_jr = 1; step();
    advance(); idle_in(); rs_ready = 1; reset = 1; step();
    lit("rstjr_take", {31'b0, take}, 0);
    lit("rstjr_sel", {30'b0, pc_sel}, 0);
    advance(); idle_in(); step();
    lit("rstjr_state", {30'b0, dbg_state}, ST_IDLE);
    lit("rstjr_err", {31'b0, err_sticky}, 0);

    // likely BNE not taken
    advance(); branch_in(COND_BNE, 1); step();
    advance(); idle_in(); ex_z = 1; step();
    lit("likely_annul", {31'b0, annul_id}, {31'b0, LIKELY_EN});
    lit("likely_take", {31'b0, take}, 0);
    advance(); idle_in(); step();
    lit("likely_annul_once", {31'b0, annul_id}, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      advance(); idle_in();
      reset    = ($urandom_range(0, 99) < 2);
      id_valid = ($urandom_range(0, 99) < 85);
      kind = $urandom_range(0, 9);
      case (kind)
        0: id_is_jump = 1;
        1: id_is_jr = 1;
        2, 3: id_is_branch = 1;
        4: begin
          id_is_jump = 1'($urandom); id_is_jr = 1'($urandom); id_is_branch = 1'($urandom);
        end
        default: ;
      endcase
      id_cond   = 3'($urandom_range(0, 7));
      id_likely = 1'($urandom);
      ex_hold   = ($urandom_range(0, 99) < 30);
      ex_z      = 1'($urandom);
      ex_n      = 1'($urandom);
      rs_ready  = ($urandom_range(0, 99) < 50);
      step();
    end

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
